// File: rtl/vga_timing_gen_if.sv
// ============================================================================
// Module      : vga_timing_gen_if
// Description : Raster timing bus between the timing generator and the
//               image-display stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface vga_timing_gen_if;
    logic        pix_en;
    logic        hor_sync;
    logic        ver_sync;
    logic        valid;
    logic [10:0] hor_pos;
    logic [10:0] ver_pos;
    logic        line_start;
    logic        frame_start;
    logic [11:0] pattern_rgb;

    // master: the timing generator
    modport master (
        input  pix_en,
        output hor_sync, ver_sync, valid, hor_pos, ver_pos,
        output line_start, frame_start, pattern_rgb
    );

    // slave: the display stage that consumes the raster timing
    modport slave (
        output pix_en,
        input  hor_sync, ver_sync, valid, hor_pos, ver_pos,
        input  line_start, frame_start, pattern_rgb
    );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : Parameterised raster timing generator (default 640x480@60).
//               Optional colour-bar generator enabled by VGA_TEST_PATTERN_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vga_timing_gen_if.master  vga
);

    localparam int c_H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_H_SYNC_START = H_ACTIVE + H_FP;
    localparam int c_H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int c_V_SYNC_START = V_ACTIVE + V_FP;
    localparam int c_V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [10:0] h_cnt_q, h_cnt_d;
    logic [10:0] v_cnt_q, v_cnt_d;
    logic        w_h_last;
    logic        w_v_last;

    assign w_h_last = (h_cnt_q == 11'(c_H_TOTAL - 1));
    assign w_v_last = (v_cnt_q == 11'(c_V_TOTAL - 1));

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (w_h_last) begin
            h_cnt_d = 11'd0;
            v_cnt_d = w_v_last ? 11'd0 : v_cnt_q + 11'd1;
        end else begin
            h_cnt_d = h_cnt_q + 11'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= 11'd0;
            v_cnt_q <= 11'd0;
        end else if (vga.pix_en) begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // Output decode of the current counter position, registered below so
    // every output describes the same pixel as hor_pos/ver_pos.
    logic w_h_active, w_v_active;
    logic w_h_in_sync, w_v_in_sync;
    logic hs_d, vs_d, valid_d, line_start_d, frame_start_d;

    assign w_h_active    = (h_cnt_q < 11'(H_ACTIVE));
    assign w_v_active    = (v_cnt_q < 11'(V_ACTIVE));
    assign w_h_in_sync   = (h_cnt_q >= 11'(c_H_SYNC_START)) && (h_cnt_q < 11'(c_H_SYNC_END));
    assign w_v_in_sync   = (v_cnt_q >= 11'(c_V_SYNC_START)) && (v_cnt_q < 11'(c_V_SYNC_END));
    assign hs_d          = w_h_in_sync ? H_SYNC_POL : ~H_SYNC_POL;
    assign vs_d          = w_v_in_sync ? V_SYNC_POL : ~V_SYNC_POL;
    assign valid_d       = w_h_active && w_v_active;
    assign line_start_d  = (h_cnt_q == 11'd0);
    assign frame_start_d = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

    logic        hs_q, vs_q, valid_q, line_start_q, frame_start_q;
    logic [10:0] hor_pos_q, ver_pos_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_q          <= ~H_SYNC_POL;
            vs_q          <= ~V_SYNC_POL;
            valid_q       <= 1'b0;
            hor_pos_q     <= 11'd0;
            ver_pos_q     <= 11'd0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (vga.pix_en) begin
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            valid_q       <= valid_d;
            hor_pos_q     <= h_cnt_q;
            ver_pos_q     <= v_cnt_q;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.hor_sync    = hs_q;
    assign vga.ver_sync    = vs_q;
    assign vga.valid       = valid_q;
    assign vga.hor_pos     = hor_pos_q;
    assign vga.ver_pos     = ver_pos_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_TEST_PATTERN_EN
    // Bar index = h*8/H_ACTIVE, found by comparing h*8 against each
    // bar boundary instead of dividing.
    logic [13:0] w_h_x8;
    logic [2:0]  w_bar;
    logic [11:0] pattern_d;
    logic [11:0] pattern_q;

    assign w_h_x8 = {h_cnt_q, 3'b000};

    always_comb begin
        w_bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (w_h_x8 >= 14'(k * H_ACTIVE)) begin
                w_bar = 3'(k);
            end
        end
    end

    always_comb begin
        pattern_d = 12'h000;
        if (valid_d) begin
            case (w_bar)
                3'd0:    pattern_d = 12'hFFF;
                3'd1:    pattern_d = 12'hFF0;
                3'd2:    pattern_d = 12'h0FF;
                3'd3:    pattern_d = 12'h0F0;
                3'd4:    pattern_d = 12'hF0F;
                3'd5:    pattern_d = 12'hF00;
                3'd6:    pattern_d = 12'h00F;
                default: pattern_d = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pattern_q <= 12'h000;
        end else if (vga.pix_en) begin
            pattern_q <= pattern_d;
        end
    end

    assign vga.pattern_rgb = pattern_q;
`else
    assign vga.pattern_rgb = 12'h000;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Scoreboard bench for vga_timing_gen: default horizontal timing,
//               shortened vertical timing (4 active, 1 FP, 2 sync, 2 BP lines).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        valid;
        logic [10:0] hp;
        logic [10:0] vp;
        logic        ls;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    exp_t sb_q[$];
    event ev_push;

    vga_timing_gen_if vga ();

    vga_timing_gen #(
        .H_ACTIVE   (640),
        .H_FP       (16),
        .H_SYNC     (96),
        .H_BP       (48),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (2),
        .H_SYNC_POL (1'b0),
        .V_SYNC_POL (1'b0)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .vga (vga.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-derived timing for this configuration:
    // line 800 px, active 0..639, hsync 656..751; frame 9 lines, active 0..3, vsync 5..6.
    function automatic logic [11:0] exp_rgb(input int h, input int v);
`ifdef VGA_TEST_PATTERN_EN
        if (h >= 640 || v >= 4) return 12'h000;
        case (h / 80)
            0:       return 12'hFFF;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            3:       return 12'h0F0;
            4:       return 12'hF0F;
            5:       return 12'hF00;
            6:       return 12'h00F;
            default: return 12'h000;
        endcase
`else
        return 12'h000;
`endif
    endfunction

    function automatic exp_t decode(input int h, input int v);
        exp_t e;
        e.hs    = !(h >= 656 && h <= 751);
        e.vs    = !(v >= 5 && v <= 6);
        e.valid = (h < 640) && (v < 4);
        e.hp    = 11'(h);
        e.vp    = 11'(v);
        e.ls    = (h == 0);
        e.fs    = (h == 0) && (v == 0);
        e.rgb   = exp_rgb(h, v);
        return e;
    endfunction

    function automatic exp_t reset_val();
        exp_t e;
        e       = '0;
        e.hs    = 1'b1;
        e.vs    = 1'b1;
        return e;
    endfunction

    int   eh = 0;
    int   ev = 0;
    exp_t last;

    task automatic push_exp(input exp_t e);
        sb_q.push_back(e);
        -> ev_push;
    endtask

    task automatic step(input bit en, input bit r);
        @(negedge clk);
        vga.pix_en = en;
        rst        = r;
        @(posedge clk);
        if (r) begin
            last = reset_val();
            eh   = 0;
            ev   = 0;
        end else if (en) begin
            last = decode(eh, ev);
            eh++;
            if (eh == 800) begin
                eh = 0;
                ev++;
                if (ev == 9) ev = 0;
            end
        end
        push_exp(last);
    endtask

    task automatic async_reset();
        #3;
        rst  = 1'b1;
        last = reset_val();
        eh   = 0;
        ev   = 0;
        push_exp(last);
    endtask

    // Monitor: compares the DUT against every queued expectation.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(ev_push);
            #1;
            while (sb_q.size() > 0) begin
                e       = sb_q.pop_front();
                a.hs    = vga.hor_sync;
                a.vs    = vga.ver_sync;
                a.valid = vga.valid;
                a.hp    = vga.hor_pos;
                a.vp    = vga.ver_pos;
                a.ls    = vga.line_start;
                a.fs    = vga.frame_start;
                a.rgb   = vga.pattern_rgb;
                checks++;
                if (a !== e) begin
                    failures++;
                    if (failures <= 20)
                        $display("FAIL pixel @%0t: got hs=%b vs=%b val=%b h=%0d v=%0d ls=%b fs=%b rgb=%h, want hs=%b vs=%b val=%b h=%0d v=%0d ls=%b fs=%b rgb=%h",
                                 $time, a.hs, a.vs, a.valid, a.hp, a.vp, a.ls, a.fs, a.rgb,
                                 e.hs, e.vs, e.valid, e.hp, e.vp, e.ls, e.fs, e.rgb);
                end
            end
        end
    end

    initial begin
        bit paused = 1'b0;
        rst        = 1'b0;
        vga.pix_en = 1'b0;
        #2;
        rst  = 1'b1;
        last = reset_val();
        push_exp(last);
        repeat (2) step(1'b1, 1'b1);

        // Two full frames plus margin, with a 5-cycle freeze at (100, 1).
        for (int i = 0; i < 2 * 7200 + 20; i++) begin
            step(1'b1, 1'b0);
            if (!paused && last.hp == 11'd100 && last.vp == 11'd1) begin
                repeat (5) step(1'b0, 1'b0);
                paused = 1'b1;
            end
        end

        // Advance to (300, 2), then assert reset between clock edges.
        for (int i = 0; i < 7200 && !(last.hp == 11'd300 && last.vp == 11'd2); i++)
            step(1'b1, 1'b0);
        async_reset();
        repeat (3) step(1'b1, 1'b1);
        for (int i = 0; i < 1700; i++)
            step(1'b1, 1'b0);

        @(negedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
